// File: rtl/decode_uop_sequencer.sv
// ---------------------------------------------------------------------------
// DecodeUopSequencer
//
// Purpose:
//   This block chooses the control-store address for each cycle in the decode
//   stage. A simple instruction goes straight from decode_address. A
//   multi-micro-op instruction is followed through the cs_next_uaddr chain.
//   A pending interrupt or fault is serviced at an instruction boundary by
//   jumping to its micro-routine. While a chain or routine runs, the
//   instruction in decode stage 1/2 is held with stall_upstream.
//
// Ports:
//   clk              : single clock, rising-edge active
//   reset            : asynchronous reset, active low
//   D2_V             : valid instruction present in decode stage 2
//   stall_in         : downstream stall, freezes all sequencer state
//   flush            : pipeline flush, returns the block to IDLE
//   decode_address   : first control-store address of the instruction
//   opcode_size      : one-byte / two-byte opcode page select
//   cs_uop_stall     : the current control word has a following micro-op
//   cs_next_uaddr    : control-store address of that following micro-op
//   int_req          : pending NMI / #GP / #PF service request
//   int_vector       : control-store address of the service micro-routine
//   ctrl_addr_out    : control-store address for the current cycle
//   ctrl_op_size_out : control-store page select
//   stall_upstream   : holds IR/EIP in decode stages 1 and 2
//   uop_count        : index of the micro-op now addressed
//   seq_state        : IDLE=00, UOP=01, INTR=10
//   uop_overflow     : one-cycle pulse when the micro-op limit is hit
//
// Configuration:
//   DECODE_UOP_LIMIT_EN - when defined, a chain reaching micro-op index 7 that
//   still requests another micro-op is cut off: uop_overflow pulses and the
//   block returns to IDLE. When undefined, uop_overflow stays 0 and the
//   micro-op index simply wraps 7 -> 0.
// ---------------------------------------------------------------------------
module decode_uop_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       D2_V,
  input  logic       stall_in,
  input  logic       flush,
  input  logic [7:0] decode_address,
  input  logic       opcode_size,
  input  logic       cs_uop_stall,
  input  logic [6:0] cs_next_uaddr,
  input  logic       int_req,
  input  logic [7:0] int_vector,
  output logic [7:0] ctrl_addr_out,
  output logic       ctrl_op_size_out,
  output logic       stall_upstream,
  output logic [2:0] uop_count,
  output logic [1:0] seq_state,
  output logic       uop_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UOP  = 2'b01,
    INTR = 2'b10
  } state_t;

  state_t     r_state;
  logic [6:0] r_saved_uaddr;
  logic [7:0] r_int_vec_q;
  logic [2:0] r_uop_count;
  logic       r_from_int;
  logic       r_uop_overflow;

  state_t     w_next_state;
  logic [6:0] w_next_saved_uaddr;
  logic [7:0] w_next_int_vec_q;
  logic [2:0] w_next_uop_count;
  logic       w_next_from_int;
  logic       w_next_uop_overflow;
  logic       w_limit_hit;

  // A chain is cut off only when the limit feature is built in.
`ifdef DECODE_UOP_LIMIT_EN
  assign w_limit_hit = (r_uop_count == 3'd7);
`else
  assign w_limit_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_saved_uaddr  <= 7'd0;
      r_int_vec_q    <= 8'd0;
      r_uop_count    <= 3'd0;
      r_from_int     <= 1'b0;
      r_uop_overflow <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_saved_uaddr  <= w_next_saved_uaddr;
      r_int_vec_q    <= w_next_int_vec_q;
      r_uop_count    <= w_next_uop_count;
      r_from_int     <= w_next_from_int;
      r_uop_overflow <= w_next_uop_overflow;
    end
  end

  // Flush beats stall, and stall beats sequencing. The overflow pulse is
  // held during a stall so that it is not lost while the pipe is frozen.
  // int_req is only looked at in IDLE, so a routine never interrupts a chain.
  always_comb begin
    w_next_state        = r_state;
    w_next_saved_uaddr  = r_saved_uaddr;
    w_next_int_vec_q    = r_int_vec_q;
    w_next_uop_count    = r_uop_count;
    w_next_from_int     = r_from_int;
    w_next_uop_overflow = 1'b0;

    if (flush) begin
      w_next_state     = IDLE;
      w_next_uop_count = 3'd0;
      w_next_from_int  = 1'b0;
    end else if (stall_in) begin
      w_next_uop_overflow = r_uop_overflow;
    end else begin
      case (r_state)
        IDLE: begin
          if (int_req) begin
            w_next_state     = INTR;
            w_next_int_vec_q = int_vector;
            w_next_from_int  = 1'b1;
          end else if (D2_V && cs_uop_stall) begin
            w_next_state       = UOP;
            w_next_saved_uaddr = cs_next_uaddr;
            w_next_uop_count   = 3'd1;
          end
        end
        INTR: begin
          if (cs_uop_stall) begin
            w_next_state       = UOP;
            w_next_saved_uaddr = cs_next_uaddr;
            w_next_uop_count   = 3'd1;
          end else begin
            w_next_state    = IDLE;
            w_next_from_int = 1'b0;
          end
        end
        UOP: begin
          if (cs_uop_stall && w_limit_hit) begin
            w_next_state        = IDLE;
            w_next_uop_count    = 3'd0;
            w_next_from_int     = 1'b0;
            w_next_uop_overflow = 1'b1;
          end else if (cs_uop_stall) begin
            w_next_saved_uaddr = cs_next_uaddr;
            w_next_uop_count   = r_uop_count + 3'd1;
          end else begin
            w_next_state     = IDLE;
            w_next_uop_count = 3'd0;
            w_next_from_int  = 1'b0;
          end
        end
        default: begin
          w_next_state     = IDLE;
          w_next_uop_count = 3'd0;
          w_next_from_int  = 1'b0;
        end
      endcase
    end
  end

  // In IDLE the decode address passes straight through, so a one-micro-op
  // instruction costs no extra cycle. Chain and routine addresses always
  // live on the one-byte page.
  always_comb begin
    ctrl_addr_out    = decode_address;
    ctrl_op_size_out = opcode_size;
    case (r_state)
      UOP: begin
        ctrl_addr_out    = {1'b0, r_saved_uaddr};
        ctrl_op_size_out = 1'b0;
      end
      INTR: begin
        ctrl_addr_out    = r_int_vec_q;
        ctrl_op_size_out = 1'b0;
      end
      default: begin
        ctrl_addr_out    = decode_address;
        ctrl_op_size_out = opcode_size;
      end
    endcase
  end

  // The last micro-op of a normal chain releases the front end in the same
  // cycle. A chain started from a routine keeps holding it, because the
  // interrupted instruction still has to issue from IDLE afterwards.
  always_comb begin
    stall_upstream = ((r_state == IDLE) && D2_V && cs_uop_stall && !int_req) ||
                     ((r_state == IDLE) && int_req) ||
                     (r_state == INTR) ||
                     ((r_state == UOP) && (cs_uop_stall || r_from_int));
  end

  assign uop_count    = r_uop_count;
  assign seq_state    = r_state;
  assign uop_overflow = r_uop_overflow;

endmodule
